// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the inverse cipher datapath.
package aes_pkg;

  localparam int AES_NR  = 14;
  localparam int BLOCK_W = 128;
  localparam int BYTE_W  = 8;
  localparam int RND_W   = $clog2(AES_NR);

  typedef enum logic {IDLE, ROUND} fsm_state_t;

  // Row-major inverse S-box; entry 0 sits in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [BYTE_W-1:0] inv_sbox(input logic [BYTE_W-1:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] gmul_9(input logic [BYTE_W-1:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [BYTE_W-1:0] gmul_b(input logic [BYTE_W-1:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [BYTE_W-1:0] gmul_d(input logic [BYTE_W-1:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [BYTE_W-1:0] gmul_e(input logic [BYTE_W-1:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul_e(a0) ^ gmul_b(a1) ^ gmul_d(a2) ^ gmul_9(a3),
            gmul_9(a0) ^ gmul_e(a1) ^ gmul_b(a2) ^ gmul_d(a3),
            gmul_d(a0) ^ gmul_9(a1) ^ gmul_e(a2) ^ gmul_b(a3),
            gmul_b(a0) ^ gmul_d(a1) ^ gmul_9(a2) ^ gmul_e(a3)};
  endfunction

endpackage

// File: rtl/aes256_decryption_core_if.sv
// Block/key/result bundle between the decryption core and its host.
interface aes256_decryption_core_if;
  logic                        start;
  logic [aes_pkg::BLOCK_W-1:0] Ciphertext;
  logic [aes_pkg::BLOCK_W-1:0] in_key0, in_key1, in_key2, in_key3, in_key4;
  logic [aes_pkg::BLOCK_W-1:0] in_key5, in_key6, in_key7, in_key8, in_key9;
  logic [aes_pkg::BLOCK_W-1:0] in_key10, in_key11, in_key12, in_key13, in_key14;
  logic [aes_pkg::BLOCK_W-1:0] Plaintext;
  logic                        finished;
  logic                        busy;

  modport master (
    output start, Ciphertext,
    output in_key0, in_key1, in_key2, in_key3, in_key4, in_key5, in_key6, in_key7,
    output in_key8, in_key9, in_key10, in_key11, in_key12, in_key13, in_key14,
    input  Plaintext, finished, busy
  );

  modport slave (
    input  start, Ciphertext,
    input  in_key0, in_key1, in_key2, in_key3, in_key4, in_key5, in_key6, in_key7,
    input  in_key8, in_key9, in_key10, in_key11, in_key12, in_key13, in_key14,
    output Plaintext, finished, busy
  );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// InvMixColumns is skipped when last is set.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic               last,
  output logic [BLOCK_W-1:0] next_state
);

  logic [BLOCK_W-1:0] sub_bytes;
  logic [BLOCK_W-1:0] added;
  logic [BLOCK_W-1:0] mixed;

  always_comb begin
    sub_bytes = '0;
    // Byte 4*c+r is taken from column (c-r) mod 4 of the same row.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_bytes[127-8*(4*c+r) -: 8] = inv_sbox(state[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    added = sub_bytes ^ round_key;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_column(added[127-32*c -: 32]);
    end
    next_state = last ? added : mixed;
  end

endmodule

// File: rtl/aes256_decryption_core.sv
// Iterative AES-256 inverse cipher, one round per clock, start/finished handshake.
// AES_DEC_ROUND_DBG_EN adds dbg_round/dbg_state observation ports.
module aes256_decryption_core
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  aes256_decryption_core_if.slave  bus
`ifdef AES_DEC_ROUND_DBG_EN
  ,
  output logic [3:0]               dbg_round,
  output logic [BLOCK_W-1:0]       dbg_state
`endif
);

  localparam int CNT_W = $clog2(NR);

  fsm_state_t          fsm;
  logic [CNT_W-1:0]    rnd;
  logic [BLOCK_W-1:0]  state_q;
  logic [BLOCK_W-1:0]  plaintext_q;
  logic                finished_q;
  logic                busy_q;
  logic [BLOCK_W-1:0]  round_keys [2**CNT_W];
  logic [BLOCK_W-1:0]  round_out;

  always_comb begin
    for (int i = 0; i < 2**CNT_W; i++) round_keys[i] = '0;
    round_keys[0]  = bus.in_key0;
    round_keys[1]  = bus.in_key1;
    round_keys[2]  = bus.in_key2;
    round_keys[3]  = bus.in_key3;
    round_keys[4]  = bus.in_key4;
    round_keys[5]  = bus.in_key5;
    round_keys[6]  = bus.in_key6;
    round_keys[7]  = bus.in_key7;
    round_keys[8]  = bus.in_key8;
    round_keys[9]  = bus.in_key9;
    round_keys[10] = bus.in_key10;
    round_keys[11] = bus.in_key11;
    round_keys[12] = bus.in_key12;
    round_keys[13] = bus.in_key13;
    round_keys[14] = bus.in_key14;
  end

  aes_inv_round u_round (
    .state      (state_q),
    .round_key  (round_keys[rnd]),
    .last       (rnd == '0),
    .next_state (round_out)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      fsm         <= IDLE;
      rnd         <= '0;
      state_q     <= '0;
      plaintext_q <= '0;
      finished_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      finished_q <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.start) begin
            state_q <= bus.Ciphertext ^ bus.in_key14;
            rnd     <= CNT_W'(NR - 1);
            busy_q  <= 1'b1;
            fsm     <= ROUND;
          end
        end
        ROUND: begin
          if (rnd != '0) begin
            state_q <= round_out;
            rnd     <= rnd - 1'b1;
          end else begin
            plaintext_q <= round_out;
            finished_q  <= 1'b1;
            busy_q      <= 1'b0;
            fsm         <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.Plaintext = plaintext_q;
  assign bus.finished  = finished_q;
  assign bus.busy      = busy_q;

`ifdef AES_DEC_ROUND_DBG_EN
  // rnd only ever returns to IDLE at zero, so it already reads 0 there.
  assign dbg_round = 4'(rnd);
  assign dbg_state = state_q;
`endif

endmodule
